uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling, start/stop
// validation and a small receive FIFO popped by the register layer.
module uart_rx_fifo #(
   parameter int unsigned CLOCK_SCALE_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH        = 4
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         enable,
   input  logic [CLOCK_SCALE_WIDTH-1:0] clockScale,
   input  logic                         rx,
   output logic [7:0]                   dataOut,
   output logic                         dataAvailable,
   input  logic                         dataRead,
   output logic                         frameError,
   output logic                         overflow,
   input  logic                         clearErrors,
   output logic                         busy
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                         state;
   state_t                         next_state;

   logic                           sync1;
   logic                           sync2;
   logic                           rx_s;

   logic [CLOCK_SCALE_WIDTH-1:0]   tick_cnt;
   logic                           tick;
   logic [3:0]                     sample_cnt;
   logic [2:0]                     bit_cnt;
   logic [7:0]                     shift;

   logic                           push;
   logic                           frame_set;

   logic [7:0]                     mem [FIFO_DEPTH];
   logic [PW-1:0]                  wr_ptr;
   logic [PW-1:0]                  rd_ptr;
   logic                           empty;
   logic                           full;
   logic                           pop;
   logic                           do_push;
   logic                           overflow_set;

   // Two-flop synchroniser for the asynchronous rx pin, idles high
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx;
         sync2 <= sync1;
      end
   end

   assign rx_s = sync2;

   // Oversample tick: one pulse every clockScale+1 cycles while a frame is active
   always_comb begin
      tick = enable && (state != IDLE) && (tick_cnt == clockScale);
   end

   // FSM state register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state and frame-completion strobes
   always_comb begin
      next_state = state;
      push       = 1'b0;
      frame_set  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && !rx_s) begin
               next_state = START;
            end
         end
         START: begin
            if (tick && (sample_cnt == 4'd7)) begin
               next_state = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && (sample_cnt == 4'd15) && (bit_cnt == 3'd7)) begin
               next_state = STOP;
            end
         end
         STOP: begin
            if (tick && (sample_cnt == 4'd15)) begin
               push       = rx_s;
               frame_set  = !rx_s;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      // Disabling abandons the frame without reporting anything
      if (!enable) begin
         next_state = IDLE;
         push       = 1'b0;
         frame_set  = 1'b0;
      end
   end

   // Tick, sample and bit counters plus the LSB-first shift register
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         tick_cnt   <= '0;
         sample_cnt <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
      end else begin
         if (!enable || (state == IDLE) || (tick_cnt == clockScale)) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + CLOCK_SCALE_WIDTH'(1);
         end

         // The mid-start re-alignment clears the count so later samples land mid-bit
         if ((state == IDLE) || ((state == START) && tick && (sample_cnt == 4'd7))) begin
            sample_cnt <= '0;
         end else if (tick) begin
            sample_cnt <= sample_cnt + 4'd1;
         end

         if (state != DATA) begin
            bit_cnt <= '0;
         end else if (tick && (sample_cnt == 4'd15)) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {rx_s, shift[7:1]};
         end
      end
   end

   // FIFO status and push/pop qualification
   always_comb begin
      empty        = (wr_ptr == rd_ptr);
      full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop          = dataRead && !empty;
      do_push      = push && (!full || pop);
      overflow_set = push && full && !pop;
   end

   // FIFO storage and pointers; the stop-bit cycle writes the completed byte
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
            wr_ptr              <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // Sticky error flags; a set event in the same cycle beats clearErrors
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         frameError <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (frame_set) begin
            frameError <= 1'b1;
         end else if (clearErrors) begin
            frameError <= 1'b0;
         end
         if (overflow_set) begin
            overflow <= 1'b1;
         end else if (clearErrors) begin
            overflow <= 1'b0;
         end
      end
   end

   // Output view of the FIFO head and receiver activity
   always_comb begin
      dataOut       = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
      dataAvailable = !empty;
      busy          = (state != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
module tb_uart_rx_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [15:0] clock_scale;
   logic        rx;
   logic [7:0]  data_out;
   logic        data_available;
   logic        data_read;
   logic        frame_error;
   logic        overflow;
   logic        clear_errors;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   uart_rx_fifo #(
      .CLOCK_SCALE_WIDTH(16),
      .FIFO_DEPTH(4)
   ) dut (
      .wb_clk_i      (clk),
      .wb_rst_i      (rst),
      .enable        (enable),
      .clockScale    (clock_scale),
      .rx            (rx),
      .dataOut       (data_out),
      .dataAvailable (data_available),
      .dataRead      (data_read),
      .frameError    (frame_error),
      .overflow      (overflow),
      .clearErrors   (clear_errors),
      .busy          (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one 8N1 frame, each bit held for cyc clock cycles; line ends idle high
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int cyc);
      rx = 1'b0;
      repeat (cyc) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (cyc) @(negedge clk);
      end
      rx = stop_bit;
      repeat (cyc) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, data_out, exp);
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
   endtask

   task automatic clear_pulse();
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
   endtask

   initial begin
      logic found;
      logic seen_busy;

      rst          = 1'b1;
      enable       = 1'b1;
      clock_scale  = 16'd0;
      rx           = 1'b1;
      data_read    = 1'b0;
      clear_errors = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_dataOut", data_out, 8'h00);
      chk("rst_avail", data_available, 1'b0);
      chk("rst_frameError", frame_error, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // 0xA5 at 16 cycles/bit, must arrive within 161 cycles of the start edge
      found = 1'b0;
      fork
         send_byte(8'hA5, 1'b1, 16);
         begin
            for (int i = 1; i <= 161 && !found; i++) begin
               @(negedge clk);
               if (data_available) found = 1'b1;
            end
         end
      join
      chk("a5_arrival", found, 1'b1);
      chk("a5_data", data_out, 8'hA5);
      pop_chk("a5_pop", 8'hA5);
      chk("a5_avail_after_pop", data_available, 1'b0);
      chk("a5_dataOut_empty", data_out, 8'h00);

      // Pop while empty is ignored
      data_read = 1'b1;
      @(negedge clk);
      data_read = 1'b0;
      chk("empty_pop_avail", data_available, 1'b0);

      // Start glitch: 4 cycles low, rejected at mid-start
      seen_busy = 1'b0;
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      chk("glitch_busy_pulse", seen_busy, 1'b1);
      chk("glitch_idle", busy, 1'b0);
      chk("glitch_fifo_empty", data_available, 1'b0);
      chk("glitch_no_frameError", frame_error, 1'b0);

      // 0x3C with stop bit low: frame error, nothing queued
      send_byte(8'h3C, 1'b0, 16);
      repeat (40) @(negedge clk);
      chk("ferr_set", frame_error, 1'b1);
      chk("ferr_fifo_empty", data_available, 1'b0);
      clear_pulse();
      chk("ferr_cleared", frame_error, 1'b0);

      // Five bytes into a 4-entry FIFO: fifth dropped
      for (int b = 1; b <= 5; b++) begin
         send_byte(8'(b), 1'b1, 16);
      end
      repeat (20) @(negedge clk);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_no_frameError", frame_error, 1'b0);
      pop_chk("ovf_pop1", 8'h01);
      pop_chk("ovf_pop2", 8'h02);
      pop_chk("ovf_pop3", 8'h03);
      pop_chk("ovf_pop4", 8'h04);
      chk("ovf_drained", data_available, 1'b0);
      clear_pulse();
      chk("ovf_cleared", overflow, 1'b0);

      // Full FIFO, pop in the exact push cycle of 0x77.
      // Start edge -> START after 3 edges, +8 START ticks, +128 data ticks,
      // +16 stop ticks: the push edge is 154.5 cycles after the start edge.
      send_byte(8'h11, 1'b1, 16);
      send_byte(8'h22, 1'b1, 16);
      send_byte(8'h33, 1'b1, 16);
      send_byte(8'h44, 1'b1, 16);
      repeat (4) @(negedge clk);
      chk("full_no_ovf", overflow, 1'b0);
      chk("full_head", data_out, 8'h11);
      fork
         send_byte(8'h77, 1'b1, 16);
         begin
            repeat (154) @(negedge clk);
            data_read = 1'b1;
            @(negedge clk);
            data_read = 1'b0;
         end
      join
      repeat (20) @(negedge clk);
      chk("pushpop_no_ovf", overflow, 1'b0);
      pop_chk("pushpop_pop1", 8'h22);
      pop_chk("pushpop_pop2", 8'h33);
      pop_chk("pushpop_pop3", 8'h44);
      pop_chk("pushpop_pop4", 8'h77);
      chk("pushpop_drained", data_available, 1'b0);

      // Reset mid-frame with one byte queued
      send_byte(8'h66, 1'b1, 16);
      repeat (4) @(negedge clk);
      chk("prerst_avail", data_available, 1'b1);
      fork
         send_byte(8'hC3, 1'b1, 16);
         begin
            repeat (72) @(negedge clk);
            chk("prerst_busy", busy, 1'b1);
            #2;
            rst = 1'b1;
            #1;
            chk("midrst_busy", busy, 1'b0);
            chk("midrst_avail", data_available, 1'b0);
            chk("midrst_dataOut", data_out, 8'h00);
            chk("midrst_frameError", frame_error, 1'b0);
            chk("midrst_overflow", overflow, 1'b0);
         end
      join
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 0x5A at 160 cycles/bit
      clock_scale = 16'd9;
      send_byte(8'h5A, 1'b1, 160);
      repeat (20) @(negedge clk);
      chk("slow_avail", data_available, 1'b1);
      chk("slow_data", data_out, 8'h5A);
      chk("slow_no_frameError", frame_error, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
